// File: rtl/mc_pkg.sv
// Shared types and encodings for the multicycle RV32I control FSM.
// Imported by mc_controller and aludec.
package mc_pkg;

    localparam int MC_STATE_W = 4;

    typedef enum logic [MC_STATE_W-1:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_TRAP     = 4'd11
    } state_t;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLT  = 4'd5;
    localparam logic [3:0] ALU_SLTU = 4'd6;
    localparam logic [3:0] ALU_SLL  = 4'd7;
    localparam logic [3:0] ALU_SRL  = 4'd8;
    localparam logic [3:0] ALU_SRA  = 4'd9;

    // ImmSrc depends only on the opcode, so it is shared as a helper.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        case (op)
            OP_STORE:  return IMM_S;
            OP_BRANCH: return IMM_B;
            OP_JAL:    return IMM_J;
            default:   return IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/mc_aludec.sv
// ALU decoder: turns the FSM's ALUOp plus funct fields into a 4-bit ALU operation.
// Module name kept as aludec so it drops into the existing datapath unchanged.
module aludec
    import mc_pkg::*;
(
    input  logic       op5,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic [1:0] alu_op,
    output logic [3:0] alu_control
);

    logic rtype_sub;

    // Only R-type (op5=1) uses funct7b5 to select sub; addi must stay add.
    assign rtype_sub = funct7b5 & op5;

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_ADD: alu_control = ALU_ADD;
            ALUOP_SUB: alu_control = ALU_SUB;
            default: begin
                case (funct3)
                    3'b000:  alu_control = rtype_sub ? ALU_SUB : ALU_ADD;
                    3'b001:  alu_control = ALU_SLL;
                    3'b010:  alu_control = ALU_SLT;
                    3'b011:  alu_control = ALU_SLTU;
                    3'b100:  alu_control = ALU_XOR;
                    3'b101:  alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
                    3'b110:  alu_control = ALU_OR;
                    default: alu_control = ALU_AND;
                endcase
            end
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle RV32I control FSM driving the shared-ALU / unified-memory datapath.
// Optional MC_MEM_WAIT_EN: FETCH, MEMREAD and MEMWRITE stall until MemReady=1.
module mc_controller
    import mc_pkg::*;
#(
    parameter int STATE_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [6:0]         op,
    input  logic [2:0]         funct3,
    input  logic               funct7b5,
    input  logic               Zero,
    input  logic               MemReady,
    output logic               PCWrite,
    output logic               AdrSrc,
    output logic               MemWrite,
    output logic               IRWrite,
    output logic [1:0]         ResultSrc,
    output logic [1:0]         ALUSrcA,
    output logic [1:0]         ALUSrcB,
    output logic               RegWrite,
    output logic [1:0]         ImmSrc,
    output logic [3:0]         ALUControl,
    output logic               Illegal,
    output logic [STATE_W-1:0] State
);

    state_t state_q, state_d;
    logic   illegal_q, illegal_d;
    logic   mem_go;

    logic       pc_write;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic [1:0] alu_op;

`ifdef MC_MEM_WAIT_EN
    assign mem_go = MemReady;
`else
    logic unused_mem_ready;
    assign unused_mem_ready = MemReady;
    assign mem_go           = 1'b1;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= S_FETCH;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            illegal_q <= illegal_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH: state_d = mem_go ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (op)
                    OP_LOAD, OP_STORE: state_d = S_MEMADR;
                    OP_RTYPE:          state_d = S_EXECUTER;
                    OP_ITYPE:          state_d = S_EXECUTEI;
                    OP_BRANCH:         state_d = S_BRANCH;
                    OP_JAL:            state_d = S_JAL;
                    default:           state_d = S_TRAP;
                endcase
            end
            S_MEMADR:   state_d = op[5] ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = mem_go ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_go ? S_FETCH : S_MEMWRITE;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BRANCH:   state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_TRAP:     state_d = S_TRAP;
            default:    state_d = S_FETCH;
        endcase
        illegal_d = illegal_q | (state_d == S_TRAP);
    end

    always_comb begin
        pc_write  = 1'b0;
        AdrSrc    = 1'b0;
        mem_write = 1'b0;
        ir_write  = 1'b0;
        reg_write = 1'b0;
        ResultSrc = RES_ALUOUT;
        ALUSrcA   = SRCA_PC;
        ALUSrcB   = SRCB_RS2;
        alu_op    = ALUOP_ADD;
        case (state_q)
            S_FETCH: begin
                ir_write  = mem_go;
                pc_write  = mem_go;
                ALUSrcB   = SRCB_FOUR;
                ResultSrc = RES_ALURESULT;
            end
            S_DECODE: begin
                ALUSrcA = SRCA_OLDPC;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMADR: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
            end
            S_MEMREAD: AdrSrc = 1'b1;
            S_MEMWB: begin
                ResultSrc = RES_DATA;
                reg_write = 1'b1;
            end
            S_MEMWRITE: begin
                AdrSrc    = 1'b1;
                mem_write = 1'b1;
            end
            S_EXECUTER: begin
                ALUSrcA = SRCA_RS1;
                alu_op  = ALUOP_FUNCT;
            end
            S_EXECUTEI: begin
                ALUSrcA = SRCA_RS1;
                ALUSrcB = SRCB_IMM;
                alu_op  = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write = 1'b1;
            S_BRANCH: begin
                // Only beq/bne are distinguished; funct3[0] inverts the Zero test.
                ALUSrcA  = SRCA_RS1;
                alu_op   = ALUOP_SUB;
                pc_write = Zero ^ funct3[0];
            end
            S_JAL: begin
                ALUSrcA  = SRCA_OLDPC;
                ALUSrcB  = SRCB_FOUR;
                pc_write = 1'b1;
            end
            default: ;
        endcase
    end

    // Enables are masked by rst_n so a reset mid-instruction never leaks a write.
    assign PCWrite  = pc_write  & rst_n;
    assign IRWrite  = ir_write  & rst_n;
    assign MemWrite = mem_write & rst_n;
    assign RegWrite = reg_write & rst_n;

    assign ImmSrc  = imm_src_of(op);
    assign Illegal = illegal_q;
    assign State   = STATE_W'(state_q);

    aludec u_aludec (
        .op5         (op[5]),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .alu_op      (alu_op),
        .alu_control (ALUControl)
    );

endmodule

// File: tb/tb_mc_controller.sv
// Directed self-checking bench for mc_controller.
// Covers the memory-wait path when compiled with MC_MEM_WAIT_EN.
module tb_mc_controller;

    logic       clk;
    logic       rst_n;
    logic [6:0] op;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, imm_src;
    logic [3:0] alu_control;
    logic [3:0] state;

    int check_count = 0;
    int fail_count  = 0;

    mc_controller #(.STATE_W(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .op         (op),
        .funct3     (funct3),
        .funct7b5   (funct7b5),
        .Zero       (zero),
        .MemReady   (mem_ready),
        .PCWrite    (pc_write),
        .AdrSrc     (adr_src),
        .MemWrite   (mem_write),
        .IRWrite    (ir_write),
        .ResultSrc  (result_src),
        .ALUSrcA    (alu_src_a),
        .ALUSrcB    (alu_src_b),
        .RegWrite   (reg_write),
        .ImmSrc     (imm_src),
        .ALUControl (alu_control),
        .Illegal    (illegal),
        .State      (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic [6:0] o, input logic [2:0] f3, input logic f7, input logic z, input logic rdy);
        op        = o;
        funct3    = f3;
        funct7b5  = f7;
        zero      = z;
        mem_ready = rdy;
    endtask

    task automatic stepCycle();
        @(posedge clk);
        #1;
    endtask

    task automatic stepAndCheckState(input string tag, input logic [3:0] expected);
        stepCycle();
        checkOutput(tag, state, expected);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL timeout: got running expected finished");
        $fatal(1, "[TB] timeout");
    end

    initial begin
        rst_n = 1'b0;
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        #12;
        checkOutput("rst_state", state, 4'd0);
        checkOutput("rst_illegal", illegal, 1'b0);
        checkOutput("rst_pcwrite", pc_write, 1'b0);
        checkOutput("rst_irwrite", ir_write, 1'b0);

        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("fetch_pcwrite", pc_write, 1'b1);
        checkOutput("fetch_irwrite", ir_write, 1'b1);
        checkOutput("fetch_srcb", alu_src_b, 2'b10);
        checkOutput("fetch_result", result_src, 2'b10);
        checkOutput("fetch_adrsrc", adr_src, 1'b0);

        // lw: 0,1,2,3,4,0
        stepAndCheckState("lw_decode", 4'd1);
        checkOutput("lw_decode_srca", alu_src_a, 2'b01);
        checkOutput("lw_decode_srcb", alu_src_b, 2'b01);
        stepAndCheckState("lw_memadr", 4'd2);
        checkOutput("lw_memadr_srca", alu_src_a, 2'b10);
        stepAndCheckState("lw_memread", 4'd3);
        checkOutput("lw_memread_adr", adr_src, 1'b1);
        checkOutput("lw_memread_regw", reg_write, 1'b0);
        stepAndCheckState("lw_memwb", 4'd4);
        checkOutput("lw_memwb_regw", reg_write, 1'b1);
        checkOutput("lw_memwb_result", result_src, 2'b01);
        stepAndCheckState("lw_done", 4'd0);

        // sw: 0,1,2,5,0
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b1);
        #1;
        checkOutput("sw_immsrc", imm_src, 2'b01);
        stepCycle();
        stepCycle();
        stepAndCheckState("sw_memwrite", 4'd5);
        checkOutput("sw_memw", mem_write, 1'b1);
        checkOutput("sw_adr", adr_src, 1'b1);
        stepAndCheckState("sw_done", 4'd0);
        checkOutput("sw_done_memw", mem_write, 1'b0);

        // beq taken, bne not taken, bne taken
        applyStimulus(7'b1100011, 3'b000, 1'b0, 1'b1, 1'b1);
        stepCycle();
        stepAndCheckState("beq_branch", 4'd9);
        checkOutput("beq_pcwrite", pc_write, 1'b1);
        checkOutput("beq_aluctl", alu_control, 4'd1);
        checkOutput("beq_immsrc", imm_src, 2'b10);
        stepAndCheckState("beq_done", 4'd0);
        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b1, 1'b1);
        stepCycle();
        stepAndCheckState("bne_branch", 4'd9);
        checkOutput("bne_z1_pcwrite", pc_write, 1'b0);
        stepAndCheckState("bne_done", 4'd0);
        applyStimulus(7'b1100011, 3'b001, 1'b0, 1'b0, 1'b1);
        stepCycle();
        stepCycle();
        checkOutput("bne_z0_pcwrite", pc_write, 1'b1);
        stepCycle();

        // R-type sub
        applyStimulus(7'b0110011, 3'b000, 1'b1, 1'b0, 1'b1);
        stepCycle();
        stepAndCheckState("sub_execr", 4'd6);
        checkOutput("sub_aluctl", alu_control, 4'd1);
        checkOutput("sub_execr_regw", reg_write, 1'b0);
        stepAndCheckState("sub_aluwb", 4'd8);
        checkOutput("sub_aluwb_regw", reg_write, 1'b1);
        checkOutput("sub_aluwb_result", result_src, 2'b00);
        stepAndCheckState("sub_done", 4'd0);

        // addi with funct7b5=1 must still add
        applyStimulus(7'b0010011, 3'b000, 1'b1, 1'b0, 1'b1);
        stepCycle();
        stepAndCheckState("addi_execi", 4'd7);
        checkOutput("addi_aluctl", alu_control, 4'd0);
        checkOutput("addi_srcb", alu_src_b, 2'b01);
        stepAndCheckState("addi_aluwb", 4'd8);
        stepAndCheckState("addi_done", 4'd0);

        // jal: 0,1,10,8,0
        applyStimulus(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b1);
        stepCycle();
        stepAndCheckState("jal_jal", 4'd10);
        checkOutput("jal_pcwrite", pc_write, 1'b1);
        checkOutput("jal_srca", alu_src_a, 2'b01);
        checkOutput("jal_srcb", alu_src_b, 2'b10);
        checkOutput("jal_immsrc", imm_src, 2'b11);
        stepAndCheckState("jal_aluwb", 4'd8);
        checkOutput("jal_regw", reg_write, 1'b1);
        stepAndCheckState("jal_done", 4'd0);

        // async reset during MEMWB
        applyStimulus(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b1);
        repeat (4) stepCycle();
        checkOutput("rstmid_memwb", state, 4'd4);
        checkOutput("rstmid_regw_before", reg_write, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rstmid_regw_after", reg_write, 1'b0);
        checkOutput("rstmid_state", state, 4'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        checkOutput("rstmid_release_state", state, 4'd0);
        checkOutput("rstmid_release_irw", ir_write, 1'b1);

        // illegal opcode traps
        applyStimulus(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b1);
        stepCycle();
        checkOutput("trap_pre_illegal", illegal, 1'b0);
        stepAndCheckState("trap_state", 4'd11);
        checkOutput("trap_illegal", illegal, 1'b1);
        repeat (10) stepCycle();
        checkOutput("trap_hold_state", state, 4'd11);
        checkOutput("trap_hold_enables", {pc_write, ir_write, mem_write, reg_write}, 4'b0000);
        checkOutput("trap_hold_illegal", illegal, 1'b1);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        checkOutput("trap_rst_illegal", illegal, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

`ifdef MC_MEM_WAIT_EN
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("wait_fetch_irw", ir_write, 1'b0);
        checkOutput("wait_fetch_pcw", pc_write, 1'b0);
        stepAndCheckState("wait_fetch_hold", 4'd0);
        mem_ready = 1'b1;
        #1;
        checkOutput("wait_fetch_go_irw", ir_write, 1'b1);
        stepCycle();
        stepAndCheckState("wait_memadr", 4'd2);
        mem_ready = 1'b0;
        stepAndCheckState("wait_mw1", 4'd5);
        checkOutput("wait_mw1_memw", mem_write, 1'b1);
        stepAndCheckState("wait_mw2", 4'd5);
        checkOutput("wait_mw2_memw", mem_write, 1'b1);
        stepAndCheckState("wait_mw3", 4'd5);
        checkOutput("wait_mw3_memw", mem_write, 1'b1);
        mem_ready = 1'b1;
        #1;
        checkOutput("wait_mw4_memw", mem_write, 1'b1);
        stepAndCheckState("wait_done", 4'd0);
        checkOutput("wait_done_memw", mem_write, 1'b0);
`else
        applyStimulus(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        #1;
        checkOutput("nowait_fetch_irw", ir_write, 1'b1);
        stepAndCheckState("nowait_decode", 4'd1);
        stepCycle();
        stepAndCheckState("nowait_memwrite", 4'd5);
        stepAndCheckState("nowait_done", 4'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
        $finish;
    end

endmodule
